lcd_text_driver: RTL and testbench

Initiator side of the 32-character text-page interface used by the display-mode blocks: sweeps `index` 0..31, reads the character each mode block returns on its 8-bit ASCII output, and writes the page to an HD44780-compatible 16x2 character LCD in 8-bit mode. Sits between the mode multiplexer and the LCD pins. It runs the power-up initialisation once, then refreshes both lines continuously.

---
 rtl/lcd_text_driver_if.sv | 22 ++
 rtl/lcd_text_driver.sv | 168 ++++++++++++++++
 tb/tb_lcd_text_driver.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_text_driver_if.sv
// Text-page / HD44780 pin bundle between the LCD driver and the mode mux + panel.
// The master drives index and the LCD pins; the slave returns char_in.
interface lcd_text_driver_if;
    logic [7:0] char_in;
    logic [4:0] index;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic       init_done;
    logic       frame_done;

    modport master (
        input  char_in,
        output index, lcd_e, lcd_rs, lcd_rw, lcd_data, init_done, frame_done
    );

    modport slave (
        output char_in,
        input  index, lcd_e, lcd_rs, lcd_rw, lcd_data, init_done, frame_done
    );
endinterface

// File: rtl/lcd_text_driver.sv
// HD44780 16x2 8-bit driver: power-up wait, 4-step init, then endless refresh of a 32-char page.
// Latency: per char 2+2+E_HIGH_CYC+2+CMD_WAIT_CYC cycles; no backpressure. LCD_CURSOR_BLINK_EN selects 0F vs 0C.
module lcd_text_driver #(
    parameter int POWERUP_CYC    = 750000,
    parameter int E_HIGH_CYC     = 25,
    parameter int CMD_WAIT_CYC   = 2000,
    parameter int CLEAR_WAIT_CYC = 82000
) (
    input  logic              clk,
    input  logic              rst,
    lcd_text_driver_if.master lcd
);
    localparam int MAX_AB  = (POWERUP_CYC > CLEAR_WAIT_CYC) ? POWERUP_CYC : CLEAR_WAIT_CYC;
    localparam int MAX_CD  = (CMD_WAIT_CYC > E_HIGH_CYC) ? CMD_WAIT_CYC : E_HIGH_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(MAX_CYC + 1) < 2 ? 2 : $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] PWR_LAST = CW'(POWERUP_CYC - 1);
    localparam logic [CW-1:0] EH_LAST  = CW'(E_HIGH_CYC - 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT_CYC - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_WAIT_CYC - 1);

`ifdef LCD_CURSOR_BLINK_EN
    localparam logic [7:0] DISP_CMD = 8'h0F;
`else
    localparam logic [7:0] DISP_CMD = 8'h0C;
`endif

    typedef enum logic [2:0] {
        S_PWRUP, S_INIT, S_ADDR, S_FETCH, S_SETUP, S_EHIGH, S_HOLD, S_WAIT
    } state_t;

    typedef enum logic [1:0] {K_INIT, K_ADDR, K_DATA} kind_t;

    state_t        state_q, state_d;
    kind_t         kind_q, kind_d;
    logic [CW-1:0] cnt_q, cnt_d, last_cnt;
    logic [1:0]    step_q, step_d;
    logic [4:0]    index_q, index_d;
    logic          e_q, e_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          init_done_q, init_done_d;
    logic          frame_done_q, frame_done_d;

    function automatic logic [7:0] init_cmd(input logic [1:0] s);
        case (s)
            2'd0:    return 8'h38;
            2'd1:    return DISP_CMD;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    // Terminal count of the current state; INIT and ADDR last a single cycle.
    always_comb begin
        last_cnt = '0;
        case (state_q)
            S_PWRUP:                 last_cnt = PWR_LAST;
            S_FETCH, S_SETUP, S_HOLD: last_cnt = CW'(1);
            S_EHIGH:                 last_cnt = EH_LAST;
            S_WAIT:                  last_cnt = (kind_q == K_INIT && step_q == 2'd3) ? CLR_LAST : CMD_LAST;
            default:                 last_cnt = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        step_d       = step_q;
        kind_d       = kind_q;
        index_d      = index_q;
        rs_d         = rs_q;
        data_d       = data_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        if (cnt_q == last_cnt) begin
            cnt_d = '0;
            case (state_q)
                S_PWRUP: state_d = S_INIT;
                S_INIT: begin
                    data_d  = init_cmd(step_q);
                    rs_d    = 1'b0;
                    kind_d  = K_INIT;
                    state_d = S_SETUP;
                end
                S_ADDR: begin
                    data_d  = index_q[4] ? 8'hC0 : 8'h80;
                    rs_d    = 1'b0;
                    kind_d  = K_ADDR;
                    state_d = S_SETUP;
                end
                S_FETCH: begin
                    data_d  = lcd.char_in;
                    rs_d    = 1'b1;
                    kind_d  = K_DATA;
                    state_d = S_SETUP;
                end
                S_SETUP: state_d = S_EHIGH;
                S_EHIGH: state_d = S_HOLD;
                S_HOLD:  state_d = S_WAIT;
                S_WAIT: begin
                    case (kind_q)
                        K_INIT: begin
                            if (step_q == 2'd3) begin
                                init_done_d = 1'b1;
                                state_d     = S_ADDR;
                            end else begin
                                step_d  = step_q + 2'd1;
                                state_d = S_INIT;
                            end
                        end
                        K_ADDR: state_d = S_FETCH;
                        default: begin
                            if (index_q == 5'd15) begin
                                index_d = 5'd16;
                                state_d = S_ADDR;
                            end else if (index_q == 5'd31) begin
                                index_d      = 5'd0;
                                frame_done_d = 1'b1;
                                state_d      = S_ADDR;
                            end else begin
                                index_d = index_q + 5'd1;
                                state_d = S_FETCH;
                            end
                        end
                    endcase
                end
                default: state_d = S_PWRUP;
            endcase
        end
        e_d = (state_d == S_EHIGH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_PWRUP;
            kind_q       <= K_INIT;
            cnt_q        <= '0;
            step_q       <= 2'd0;
            index_q      <= 5'd0;
            e_q          <= 1'b0;
            rs_q         <= 1'b0;
            data_q       <= 8'h00;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            cnt_q        <= cnt_d;
            step_q       <= step_d;
            index_q      <= index_d;
            e_q          <= e_d;
            rs_q         <= rs_d;
            data_q       <= data_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign lcd.index      = index_q;
    assign lcd.lcd_e      = e_q;
    assign lcd.lcd_rs     = rs_q;
    assign lcd.lcd_rw     = 1'b0;
    assign lcd.lcd_data   = data_q;
    assign lcd.init_done  = init_done_q;
    assign lcd.frame_done = frame_done_q;
endmodule

// File: tb/tb_lcd_text_driver.sv
// Scoreboarded bench for lcd_text_driver: expected LCD transfers are queued from a page model,
// a negedge monitor pops one per lcd_e strobe and checks pin timing.
module tb_lcd_text_driver;
    localparam int PWR  = 20;
    localparam int EH   = 3;
    localparam int CMDW = 5;
    localparam int CLRW = 10;
`ifdef LCD_CURSOR_BLINK_EN
    localparam logic [7:0] DISP_CMD = 8'h0F;
`else
    localparam logic [7:0] DISP_CMD = 8'h0C;
`endif

    typedef struct {
        logic       rs;
        logic [7:0] dat;
        bit         is_init;
        bit         is_clear;
    } exp_t;

    logic clk;
    logic rst;
    lcd_text_driver_if u_if();

    lcd_text_driver #(
        .POWERUP_CYC(PWR), .E_HIGH_CYC(EH), .CMD_WAIT_CYC(CMDW), .CLEAR_WAIT_CYC(CLRW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .lcd(u_if)
    );

    int         checks   = 0;
    int         failures = 0;
    int         fd_count = 0;
    exp_t       exp_q[$];
    logic [7:0] char_tab [32];
    bit         garble = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic push_exp(input logic rs, input logic [7:0] dat, input bit is_init, input bit is_clear);
        exp_t e;
        e.rs = rs; e.dat = dat; e.is_init = is_init; e.is_clear = is_clear;
        exp_q.push_back(e);
    endtask

    task automatic push_init();
        push_exp(1'b0, 8'h38, 1'b1, 1'b0);
        push_exp(1'b0, DISP_CMD, 1'b1, 1'b0);
        push_exp(1'b0, 8'h06, 1'b1, 1'b0);
        push_exp(1'b0, 8'h01, 1'b1, 1'b1);
    endtask

    // Page model: line-1 address, chars 0..15, line-2 address, chars 16..31.
    task automatic push_frame(input int upto);
        push_exp(1'b0, 8'h80, 1'b0, 1'b0);
        for (int i = 0; i < upto; i++) begin
            if (i == 16) push_exp(1'b0, 8'hC0, 1'b0, 1'b0);
            push_exp(1'b1, char_tab[i], 1'b0, 1'b0);
        end
    endtask

    task automatic set_tab(input bit rnd);
        for (int i = 0; i < 32; i++)
            char_tab[i] = rnd ? 8'($urandom_range(32, 126)) : 8'(8'h41 + i);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_index"}, 32'(u_if.index), 0);
        chk({tag, "_lcd_e"}, 32'(u_if.lcd_e), 0);
        chk({tag, "_lcd_rs"}, 32'(u_if.lcd_rs), 0);
        chk({tag, "_lcd_rw"}, 32'(u_if.lcd_rw), 0);
        chk({tag, "_lcd_data"}, 32'(u_if.lcd_data), 0);
        chk({tag, "_init_done"}, 32'(u_if.init_done), 0);
        chk({tag, "_frame_done"}, 32'(u_if.frame_done), 0);
    endtask

    task automatic quiet_check(input string nm);
        bit seen = 1'b0;
        repeat (PWR) begin
            @(negedge clk);
            if (u_if.lcd_e) seen = 1'b1;
        end
        chk(nm, 32'(seen), 0);
    endtask

    task automatic wait_fd(input string nm);
        bit got = 1'b0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clk);
            if (u_if.frame_done) got = 1'b1;
        end
        chk(nm, 32'(got), 1);
    endtask

    // Registered responder; when garbling, char_in is only correct in the cycle
    // before the fetch sample edge (HOLD 2 + WAIT + FETCH 2 after a strobe falls).
    initial begin
        int         since = 100;
        logic       pe    = 1'b0;
        logic [4:0] il    = 5'd0;
        logic [7:0] good;
        u_if.char_in = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (pe && !u_if.lcd_e) since = 0;
            else if (since < 1000) since++;
            pe   = u_if.lcd_e;
            good = char_tab[il];
            il   = u_if.index;
            if (garble && since != 2 + CMDW + 1)
                u_if.char_in = good ^ 8'($urandom_range(1, 255));
            else
                u_if.char_in = good;
        end
    end

    initial begin
        logic       pe = 1'b0, pfd = 1'b0, prv_v = 1'b0;
        int         hi_cnt = 0, since_fall = 0, post = 0, low;
        logic [8:0] h1 = '0, h2 = '0, val_hi = '0, cur;
        exp_t       e, prv;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pe = 1'b0; pfd = 1'b0; prv_v = 1'b0;
                hi_cnt = 0; since_fall = 0; post = 0;
                h1 = '0; h2 = '0;
            end else begin
                cur = {u_if.lcd_rs, u_if.lcd_data};
                chk("lcd_rw_zero", 32'(u_if.lcd_rw), 0);
                if (u_if.lcd_e && !pe) begin
                    chk("setup_stable", 32'({h2, h1}), 32'({cur, cur}));
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_strobe actual=%0h required=none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        chk("strobe_rs_data", 32'(cur), 32'({e.rs, e.dat}));
                        chk("init_done_at_strobe", 32'(u_if.init_done), 32'(!e.is_init));
                        if (prv_v) begin
                            low = since_fall + 1;
                            if (prv.is_clear)
                                chk("clear_gap_ge14", 32'(low >= 2 + CLRW + 2), 1);
                            else if (prv.rs && e.rs)
                                chk("char_gap", 32'(low), 32'(2 + CMDW + 2 + 2));
                            else
                                chk("cmd_gap_ge9", 32'(low >= 2 + CMDW + 2), 1);
                        end
                        prv   = e;
                        prv_v = 1'b1;
                    end
                    hi_cnt = 1;
                    val_hi = cur;
                end else if (u_if.lcd_e) begin
                    hi_cnt++;
                    chk("data_stable_high", 32'(cur), 32'(val_hi));
                end else if (pe) begin
                    chk("e_high_width", 32'(hi_cnt), EH);
                    chk("hold_stable", 32'(cur), 32'(val_hi));
                    since_fall = 0;
                    post = 1;
                end else begin
                    if (post > 0) begin
                        chk("hold_stable", 32'(cur), 32'(val_hi));
                        post--;
                    end
                    since_fall++;
                end
                if (u_if.frame_done) begin
                    fd_count++;
                    chk("frame_done_index0", 32'(u_if.index), 0);
                    chk("frame_done_1cyc", 32'(pfd), 0);
                end
                h2  = h1;
                h1  = cur;
                pe  = u_if.lcd_e;
                pfd = u_if.frame_done;
            end
        end
    end

    initial begin
        bit found = 1'b0;
        rst = 1'b1;
        set_tab(1'b0);
        #3 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");

        push_init();
        push_frame(32);
        rst = 1'b1;
        quiet_check("powerup_quiet");
        wait_fd("frame0_done");

        set_tab(1'b1);
        garble = 1'b1;
        push_frame(32);
        wait_fd("frame1_done");

        set_tab(1'b1);
        garble = 1'b0;
        push_frame(8);
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (u_if.index == 5'd7 && u_if.lcd_e) found = 1'b1;
        end
        chk("reach_index7_strobe", 32'(found), 1);
        #2 rst = 1'b0;
        #1 check_reset_outputs("midreset");
        chk("queue_drained_at_reset", 32'(exp_q.size()), 0);
        exp_q.delete();

        repeat (3) @(negedge clk);
        set_tab(1'b0);
        garble = 1'b1;
        push_init();
        push_frame(32);
        rst = 1'b1;
        quiet_check("repowerup_quiet");
        wait_fd("frame3_done");

        chk("queue_empty_end", 32'(exp_q.size()), 0);
        chk("frame_done_count", 32'(fd_count), 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
